ps2_mouse_tx: RTL and testbench

Device-side PS/2 mouse emulator: accepts a signed movement delta and button state, builds a standard 3-byte PS/2 mouse movement packet, and serializes it onto PS2_CLK/PS2_DAT as the device. The device generates the clock. Used as a bench and board-level stimulus source for the team's host-side mouse path. It sits on the opposite end of the same open-drain PS/2 bus.

---
 rtl/ps2_mouse_tx.sv | 236 +++++++++++++++++++++++
 tb/tb_ps2_mouse_tx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_tx.sv
// ps2_mouse_tx -- device-side PS/2 mouse emulator.
// Latches a signed X/Y delta plus button state, builds the standard 3-byte
// movement packet (deltas clamped to 9-bit signed with overflow flags) and
// shifts it out as the device, generating PS2_CLK itself. Both bus lines are
// open-drain: only ever driven low or released.
// Optional build macro: MOUSE_TX_INHIBIT_EN adds host-inhibit support (a host
// holding PS2_CLK low aborts the current frame and restarts the packet).
`timescale 1ns/1ps

module ps2_mouse_tx #(
  parameter int CLK_DIV = 2000,  // system cycles per PS/2 clock half-period
  parameter int GAP     = 4000   // idle cycles after each byte's stop bit
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       send,
  output logic       ready,
  input  logic [9:0] dx,
  input  logic [9:0] dy,
  input  logic       left_button,
  input  logic       right_button,
  output logic       done,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT
);

  // FSM encoding
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_BUS = 3'd1;
  localparam logic [2:0] ST_HIGH     = 3'd2;
  localparam logic [2:0] ST_LOW      = 3'd3;
  localparam logic [2:0] ST_GAP      = 3'd4;

  // One shared phase counter covers both the half-period and the byte gap.
  localparam int CNT_MAX = (CLK_DIV > GAP) ? CLK_DIV : GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       bit_reg, bit_next;
  logic [1:0]       byte_reg, byte_next;
  logic [2:0][7:0]  pkt_reg;
  logic             clk_low_reg;
  logic             dat_low_reg;
  logic             done_reg, done_next;
  logic [1:0]       line_meta_reg;
  logic [1:0]       line_sync_reg;

  logic             accept;
  logic [1:0]       line_in;
  logic             bus_clk_high;
  logic             host_inhibit;
  logic [7:0]       cur_byte;
  logic [10:0]      frame;
  logic             cur_bit;

  // Saturation datapath, index 0 = X, index 1 = Y
  logic [1:0][9:0]  delta;
  logic [1:0]       ovf;
  logic [1:0]       sgn;
  logic [1:0][7:0]  mag;

  assign ready  = (state_reg == ST_IDLE);
  assign accept = send && ready;
  assign done   = done_reg;
  assign delta  = {dy, dx};

  // A 10-bit value fits in 9 bits exactly when its top two bits agree. The
  // clamped sign always equals the original sign, so bit 9 serves as sign.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sat
      assign ovf[gi] = delta[gi][9] ^ delta[gi][8];
      assign sgn[gi] = delta[gi][9];
      assign mag[gi] = ovf[gi] ? (delta[gi][9] ? 8'h00 : 8'hFF) : delta[gi][7:0];
    end
  endgenerate

  // Bus lines: 0 or released, never driven high
  assign PS2_CLK = clk_low_reg ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_low_reg ? 1'b0 : 1'bz;
  assign line_in = {PS2_DAT, PS2_CLK};

  // Two-flop synchronizer for both bus lines; idle bus reads high
  always_ff @(posedge clock) begin
    if (reset) begin
      line_meta_reg <= 2'b11;
      line_sync_reg <= 2'b11;
    end else begin
      line_meta_reg <= line_in;
      line_sync_reg <= line_meta_reg;
    end
  end

`ifdef MOUSE_TX_INHIBIT_EN
  // Our own clock release reaches the synchronizer output three cycles after
  // HIGH is entered, so the end-of-phase inhibit test needs CLK_DIV >= 4.
  logic unused_dat_sync;
  assign bus_clk_high    = line_sync_reg[0];
  assign host_inhibit    = ~line_sync_reg[0];
  assign unused_dat_sync = line_sync_reg[1];
`else
  // Without inhibit support the bus is never observed.
  logic unused_line_sync;
  assign bus_clk_high     = 1'b1;
  assign host_inhibit     = 1'b0;
  assign unused_line_sync = ^line_sync_reg;
`endif

  // Packet registers: built from live inputs only on the accept cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_reg <= '0;
    end else if (accept) begin
      pkt_reg[0] <= {ovf[1], ovf[0], sgn[1], sgn[0], 1'b1, 1'b0,
                     right_button, left_button};
      pkt_reg[1] <= mag[0];
      pkt_reg[2] <= mag[1];
    end
  end

  // Current byte and its 11-bit frame: start 0, data LSB first, odd parity, stop 1
  always_comb begin
    case (byte_reg)
      2'd0:    cur_byte = pkt_reg[0];
      2'd1:    cur_byte = pkt_reg[1];
      default: cur_byte = pkt_reg[2];
    endcase
    frame   = {1'b1, ~^cur_byte, cur_byte, 1'b0};
    cur_bit = frame[bit_reg];
  end

  // Next-state logic for the bit/byte sequencer
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    byte_next  = byte_reg;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_WAIT_BUS;
          byte_next  = 2'd0;
          cnt_next   = '0;
        end
      end
      ST_WAIT_BUS: begin
        if (bus_clk_high) begin
          state_next = ST_HIGH;
          bit_next   = 4'd0;
          cnt_next   = '0;
        end
      end
      ST_HIGH: begin
        if (cnt_reg == DIV_LAST) begin
          cnt_next = '0;
          if (host_inhibit) begin
            // Host is holding the clock: drop the frame, resend whole packet
            state_next = ST_WAIT_BUS;
            byte_next  = 2'd0;
          end else begin
            state_next = ST_LOW;
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      ST_LOW: begin
        if (cnt_reg == DIV_LAST) begin
          cnt_next = '0;
          if (bit_reg == 4'd10) begin
            state_next = ST_GAP;
          end else begin
            state_next = ST_HIGH;
            bit_next   = bit_reg + 4'd1;
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      ST_GAP: begin
        // The gap counter stalls while the host inhibits the bus
        if (!host_inhibit) begin
          if (cnt_reg == GAP_LAST) begin
            cnt_next = '0;
            if (byte_reg == 2'd2) begin
              state_next = ST_IDLE;
              done_next  = 1'b1;
            end else begin
              state_next = ST_WAIT_BUS;
              byte_next  = byte_reg + 2'd1;
            end
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= 4'd0;
      byte_reg  <= 2'd0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      byte_reg  <= byte_next;
      done_reg  <= done_next;
    end
  end

  // Registered line drivers: follow the state one cycle later, glitch-free
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_low_reg <= 1'b0;
      dat_low_reg <= 1'b0;
    end else begin
      clk_low_reg <= (state_reg == ST_LOW);
      dat_low_reg <= ((state_reg == ST_HIGH) || (state_reg == ST_LOW)) && !cur_bit;
    end
  end

endmodule

// File: tb/tb_ps2_mouse_tx.sv
// tb_ps2_mouse_tx -- randomized self-checking bench for ps2_mouse_tx.
// Open-drain bus with pull-ups and a host-side sampler on the falling edge of
// PS2_CLK; expected packets come from an arithmetic model of the packet rules.
// Build with +define+MOUSE_TX_INHIBIT_EN to include the host-inhibit scenario.
`timescale 1ns/1ps

module tb_ps2_mouse_tx;

  localparam int CLK_DIV  = 4;
  localparam int GAP      = 8;
  localparam int PKT_LAT  = 3 + 3 * (22 * CLK_DIV + GAP);   // 291

  logic       clock = 1'b0;
  logic       reset;
  logic       send;
  logic [9:0] dx;
  logic [9:0] dy;
  logic       lb;
  logic       rb;
  wire        ready;
  wire        done;
  wire        ps2_clk;
  wire        ps2_dat;

  logic host_clk_low = 1'b0;

  pullup (ps2_clk);
  pullup (ps2_dat);
  assign ps2_clk = host_clk_low ? 1'b0 : 1'bz;

  ps2_mouse_tx #(.CLK_DIV(CLK_DIV), .GAP(GAP)) dut (
    .clock        (clock),
    .reset        (reset),
    .send         (send),
    .ready        (ready),
    .dx           (dx),
    .dy           (dy),
    .left_button  (lb),
    .right_button (rb),
    .done         (done),
    .PS2_CLK      (ps2_clk),
    .PS2_DAT      (ps2_dat)
  );

  always #5 clock = ~clock;

  int   cyc = 0;
  int   done_cnt = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   rx_q[$];
  bit   rx_en = 1'b1;
  logic prev_ps2_clk = 1'b1;

  always @(posedge clock) cyc <= cyc + 1;

  // Host-side sampler: capture PS2_DAT on each falling edge of PS2_CLK
  always @(negedge clock) begin
    if (rx_en && prev_ps2_clk === 1'b1 && ps2_clk === 1'b0)
      rx_q.push_back(ps2_dat === 1'b1);
    prev_ps2_clk <= ps2_clk;
  end

  always @(negedge clock) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check_eq(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               tag, actual, actual, expected, expected);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Reference model: clamp each delta to -256..255 and assemble the packet
  function automatic logic [23:0] expect_bytes(input int x, input int y, input bit l, input bit r);
    int cx, cy;
    bit xo, yo;
    logic [7:0] b0, b1, b2;
    cx = x; xo = 1'b0;
    cy = y; yo = 1'b0;
    if (cx > 255) begin cx = 255; xo = 1'b1; end
    else if (cx < -256) begin cx = -256; xo = 1'b1; end
    if (cy > 255) begin cy = 255; yo = 1'b1; end
    else if (cy < -256) begin cy = -256; yo = 1'b1; end
    b1 = 8'(cx & 255);
    b2 = 8'(cy & 255);
    b0 = {yo, xo, (cy < 0), (cx < 0), 1'b1, 1'b0, r, l};
    return {b2, b1, b0};
  endfunction

  // Decode the captured bit stream as three 11-bit frames and compare
  task automatic check_frames(input string pfx, input logic [23:0] exp_bytes);
    logic [7:0] got, e;
    int ones;
    check_eq({pfx, "_nbits"}, rx_q.size(), 33);
    if (rx_q.size() >= 33) begin
      for (int k = 0; k < 3; k++) begin
        got = '0;
        for (int j = 0; j < 8; j++) got[j] = rx_q[11*k + 1 + j];
        e = exp_bytes[8*k +: 8];
        ones = 0;
        for (int j = 0; j < 8; j++) ones += int'(e[j]);
        check_eq($sformatf("%s_b%0d_start", pfx, k), int'(rx_q[11*k]), 0);
        check_eq($sformatf("%s_b%0d_data", pfx, k), int'(got), int'(e));
        check_eq($sformatf("%s_b%0d_parity", pfx, k), int'(rx_q[11*k + 9]), (ones % 2 == 0) ? 1 : 0);
        check_eq($sformatf("%s_b%0d_stop", pfx, k), int'(rx_q[11*k + 10]), 1);
      end
    end
  endtask

  // One complete packet with timing checks; inputs are scrambled after accept
  task automatic run_packet(input string pfx, input int x, input int y, input bit l, input bit r);
    int w, acc, d0, lat;
    logic [23:0] exp;
    w = 0;
    while (ready !== 1'b1 && w < 2000) begin tick; w++; end
    check_eq({pfx, "_ready_in"}, int'(ready), 1);
    exp = expect_bytes(x, y, l, r);
    rx_q.delete();
    d0 = done_cnt;
    dx = 10'(x); dy = 10'(y); lb = l; rb = r; send = 1'b1;
    tick;
    acc = cyc;
    send = 1'b0;
    dx = 10'($urandom); dy = 10'($urandom); lb = 1'($urandom); rb = 1'($urandom);
    check_eq({pfx, "_ready_drop"}, int'(ready), 0);
    tick;
    check_eq({pfx, "_dat_hold"}, int'(ps2_dat), 1);
    tick;
    check_eq({pfx, "_start_edge"}, int'(ps2_dat), 0);
    while (done !== 1'b1 && (cyc - acc) < 2000) tick;
    lat = cyc - acc;
    check_eq({pfx, "_done_lat"}, lat, PKT_LAT);
    check_eq({pfx, "_ready_done"}, int'(ready), 1);
    tick;
    check_eq({pfx, "_done_width"}, int'(done), 0);
    check_eq({pfx, "_done_count"}, done_cnt - d0, 1);
    check_frames(pfx, exp);
    $display("pkt %s dx=%0d dy=%0d L=%0d R=%0d expected=%06h bits=%0d latency=%0d",
             pfx, x, y, l, r, exp, rx_q.size(), lat);
  endtask

  int edge_vals[8] = '{255, 256, -256, -257, 0, -1, 511, -512};

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int x, y, w, d0, n, hs_ready, t_done, t_re;
    logic [23:0] exp;

    reset = 1'b1; send = 1'b0; dx = '0; dy = '0; lb = 1'b0; rb = 1'b0;
    repeat (3) tick;
    check_eq("rst_ready", int'(ready), 1);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_clk", int'(ps2_clk), 1);
    check_eq("rst_dat", int'(ps2_dat), 1);
    reset = 1'b0;
    tick;

    // Directed packets from the plan
    run_packet("basic", 5, -3, 1'b1, 1'b0);
    run_packet("sat", 300, -400, 1'b0, 1'b0);
    run_packet("edge", -256, 255, 1'b0, 1'b0);

    // Randomized packets, mixing full-range and near-clamp values
    for (int i = 0; i < 8; i++) begin
      x = ($urandom_range(0, 1) == 1) ? edge_vals[$urandom_range(0, 7)] : int'($urandom_range(0, 1023)) - 512;
      y = ($urandom_range(0, 1) == 1) ? edge_vals[$urandom_range(0, 7)] : int'($urandom_range(0, 1023)) - 512;
      run_packet($sformatf("rnd%0d", i), x, y, 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 5)) tick;
    end

    // Handshake: send held high, re-accept only when ready returns
    x = int'($urandom_range(0, 1023)) - 512;
    y = int'($urandom_range(0, 1023)) - 512;
    exp = expect_bytes(x, y, 1'b1, 1'b1);
    rx_q.delete();
    d0 = done_cnt;
    hs_ready = 0; t_done = -1; t_re = -1;
    dx = 10'(x); dy = 10'(y); lb = 1'b1; rb = 1'b1; send = 1'b1;
    for (int i = 0; i < 500; i++) begin
      tick;
      if (done === 1'b1 && t_done < 0) begin
        t_done = i;
        check_frames("hs1", exp);
        rx_q.delete();
      end
      if (ready === 1'b1) hs_ready++;
      if (t_done >= 0 && t_re < 0 && ready !== 1'b1) t_re = i;
    end
    send = 1'b0;
    check_eq("hs_done_at", t_done, PKT_LAT);
    check_eq("hs_reaccept", t_re - t_done, 1);
    check_eq("hs_ready_cycles", hs_ready, 1);
    check_eq("hs_done_count", done_cnt - d0, 1);
    w = 0;
    while (done !== 1'b1 && w < 2000) begin tick; w++; end
    tick;
    check_eq("hs_done_count2", done_cnt - d0, 2);
    check_frames("hs2", exp);
    $display("pkt hs dx=%0d dy=%0d expected=%06h done_at=%0d reaccept=%0d", x, y, exp, t_done, t_re);

    // Reset during the LOW phase of byte 1 bit 4 (dx=5 makes that bit 0)
    rx_q.delete();
    dx = 10'd5; dy = 10'(-3); lb = 1'b0; rb = 1'b0; send = 1'b1;
    tick;
    send = 1'b0;
    w = 0;
    while (rx_q.size() < 16 && w < 1000) begin tick; w++; end
    check_eq("mid_reached", rx_q.size(), 16);
    check_eq("mid_clk_low", int'(ps2_clk), 0);
    check_eq("mid_dat_low", int'(ps2_dat), 0);
    reset = 1'b1;
    tick;
    check_eq("mid_rst_clk", int'(ps2_clk), 1);
    check_eq("mid_rst_dat", int'(ps2_dat), 1);
    check_eq("mid_rst_ready", int'(ready), 1);
    check_eq("mid_rst_done", int'(done), 0);
    reset = 1'b0;
    d0 = done_cnt;
    n = rx_q.size();
    repeat (400) tick;
    check_eq("mid_no_done", done_cnt - d0, 0);
    check_eq("mid_no_bits", rx_q.size(), n);
    $display("pkt reset_mid bits_before=%0d done_after=%0d", n, done_cnt - d0);

`ifdef MOUSE_TX_INHIBIT_EN
    // Host inhibit during byte 2: frame aborts, whole packet resent once
    x = int'($urandom_range(0, 1023)) - 512;
    y = int'($urandom_range(0, 1023)) - 512;
    exp = expect_bytes(x, y, 1'b0, 1'b1);
    rx_q.delete();
    d0 = done_cnt;
    dx = 10'(x); dy = 10'(y); lb = 1'b0; rb = 1'b1; send = 1'b1;
    tick;
    send = 1'b0;
    w = 0;
    while (rx_q.size() < 25 && w < 1000) begin tick; w++; end
    check_eq("inh_reached", rx_q.size(), 25);
    rx_en = 1'b0;
    host_clk_low = 1'b1;
    repeat (50) tick;
    check_eq("inh_no_done", done_cnt - d0, 0);
    check_eq("inh_dat_rel", int'(ps2_dat), 1);
    rx_q.delete();
    host_clk_low = 1'b0;
    rx_en = 1'b1;
    w = 0;
    while (done !== 1'b1 && w < 2000) begin tick; w++; end
    tick;
    check_eq("inh_done_count", done_cnt - d0, 1);
    check_frames("inh", exp);
    repeat (400) tick;
    check_eq("inh_single_done", done_cnt - d0, 1);
    $display("pkt inhibit dx=%0d dy=%0d expected=%06h bits=%0d", x, y, exp, rx_q.size());
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
